// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared lane widths, row type and feeder state encoding
package systolic_pkg;

  localparam int DW    = 32;
  localparam int LANES = 4;
  // Rows pack as {lane4, lane3, lane2, lane1}; lane1 sits in bits [DW-1:0]
  localparam int ROW_W = LANES * DW;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_bank.sv
// rtl/systolic_feeder_bank.sv - row register file, one write port, one registered read port
module feeder_bank #(
  parameter int W  = 128,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the lane outputs, so it reads as zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - ping-pong row buffer emitting DEPTH-row bursts with start pulse and idle gap
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DW    = systolic_pkg::DW,
  parameter int DEPTH = 10,
  parameter int GAP   = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_row,
  output logic                start,
  output logic [DW-1:0]       x01,
  output logic [DW-1:0]       x02,
  output logic [DW-1:0]       x03,
  output logic [DW-1:0]       x04,
  output logic                x_last,
  output logic                busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  logic [1:0]          full;
  logic                wbank;
  logic                rbank;
  logic [IW-1:0]       wcnt;
  logic [IW-1:0]       rcnt;
  logic [GW-1:0]       gapcnt;
  feeder_state_t       state;
  logic                accept;
  logic                fill_done;
  logic                launch;
  logic                drain_done;
  logic                rd_en;
  logic [IW-1:0]       rd_idx;
  logic [1:0]          set_mask;
  logic [1:0]          clr_mask;
  logic [LANES*DW-1:0] rd_row;

  assign in_ready   = !full[wbank] && !rst;
  assign accept     = in_valid && in_ready;
  assign fill_done  = accept && (wcnt == LAST_IDX);
  // Launch is allowed from IDLE or from the final gap cycle, so spacing is exactly GAP+1
  assign launch     = (state != ST_BURST) && (gapcnt == '0) && full[rbank];
  // The bank is released as its last row is read, letting fill reuse it one cycle earlier
  assign drain_done = (state == ST_BURST) && (rcnt == LAST_IDX);
  assign rd_en      = launch || (state == ST_BURST);
  assign rd_idx     = launch ? '0 : rcnt;
  assign set_mask   = fill_done  ? (2'b01 << wbank) : 2'b00;
  assign clr_mask   = drain_done ? (2'b01 << rbank) : 2'b00;

  feeder_bank #(
    .W  (LANES * DW),
    .AW (IW + 1)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr ({wbank, wcnt}),
    .wdata (in_row),
    .re    (rd_en),
    .raddr ({rbank, rd_idx}),
    .rdata (rd_row)
  );

  assign x01 = rd_row[0*DW +: DW];
  assign x02 = rd_row[1*DW +: DW];
  assign x03 = rd_row[2*DW +: DW];
  assign x04 = rd_row[3*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (accept) begin
      if (fill_done) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Fill and drain always target different banks, so set and clear never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else     full <= (full | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rbank  <= 1'b0;
      rcnt   <= '0;
      gapcnt <= '0;
      start  <= 1'b0;
      x_last <= 1'b0;
      busy   <= 1'b0;
    end else begin
      start  <= launch;
      x_last <= drain_done;
      if (launch) begin
        state <= ST_BURST;
        rcnt  <= IW'(1);
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_BURST: begin
            busy <= 1'b1;
            if (drain_done) begin
              rbank  <= ~rbank;
              rcnt   <= '0;
              gapcnt <= GAP_LOAD;
              state  <= ST_GAP;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (gapcnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              gapcnt <= gapcnt - 1'b1;
              busy   <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
